// File: rtl/alu_cmd_issuer.sv
// Host-side command issuer for the 4-bit ALU: queues tagged commands in a FIFO,
// drives them onto the ALU req/ack interface and returns tagged responses.
module alu_cmd_issuer #(
    parameter int DATA_W  = 4,
    parameter int OPC_W   = 3,
    parameter int TAG_W   = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [OPC_W-1:0]           cmd_opcode,
    input  logic [DATA_W-1:0]          cmd_op1,
    input  logic [DATA_W-1:0]          cmd_op2,
    input  logic [TAG_W-1:0]           cmd_tag,
    output logic                       alu_req,
    output logic [OPC_W-1:0]           alu_opcode,
    output logic [DATA_W-1:0]          alu_op1,
    output logic [DATA_W-1:0]          alu_op2,
    input  logic                       alu_ack,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic                       alu_carry,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_result,
    output logic                       rsp_carry,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_timeout,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam int ENT_W = OPC_W + 2 * DATA_W + TAG_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [ENT_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ready_en;
    logic [TMR_W-1:0]   r_timer;

    logic [OPC_W-1:0]   r_alu_opcode;
    logic [DATA_W-1:0]  r_alu_op1;
    logic [DATA_W-1:0]  r_alu_op2;
    logic [TAG_W-1:0]   r_issue_tag;
    logic [DATA_W-1:0]  r_rsp_result;
    logic               r_rsp_carry;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic               r_rsp_timeout;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_tmr_last;
    logic [ENT_W-1:0]   w_head;

    // cmd_ready is held low until the first clock after reset release
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == CNT_W'(0));
    assign cmd_ready  = r_ready_en & ~w_full;
    assign w_push     = cmd_valid & cmd_ready;
    assign w_pop      = (r_state == S_IDLE) & ~w_empty;
    assign w_tmr_last = (r_timer == TMR_W'(TIMEOUT - 1));
    assign w_head     = r_mem[r_rptr];

    assign alu_req     = (r_state == S_REQ);
    assign rsp_valid   = (r_state == S_RESP);
    assign busy        = (r_state != S_IDLE);
    assign alu_opcode  = r_alu_opcode;
    assign alu_op1     = r_alu_op1;
    assign alu_op2     = r_alu_op2;
    assign rsp_result  = r_rsp_result;
    assign rsp_carry   = r_rsp_carry;
    assign rsp_tag     = r_rsp_tag;
    assign rsp_timeout = r_rsp_timeout;
    assign fifo_count  = r_count;

    // FIFO storage; contents need no reset since occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_opcode, cmd_op1, cmd_op2, cmd_tag};
        end
    end

    // FIFO pointers, occupancy and the post-reset ready enable
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr     <= PTR_W'(0);
            r_rptr     <= PTR_W'(0);
            r_count    <= CNT_W'(0);
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; an ack in the final timer cycle beats the timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_REQ;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (alu_ack || w_tmr_last) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_RESP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Issue registers, request timer and response capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_alu_opcode  <= OPC_W'(0);
            r_alu_op1     <= DATA_W'(0);
            r_alu_op2     <= DATA_W'(0);
            r_issue_tag   <= TAG_W'(0);
            r_timer       <= TMR_W'(0);
            r_rsp_result  <= DATA_W'(0);
            r_rsp_carry   <= 1'b0;
            r_rsp_tag     <= TAG_W'(0);
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_alu_opcode, r_alu_op1, r_alu_op2, r_issue_tag} <= w_head;
                        r_timer <= TMR_W'(0);
                    end
                end
                S_REQ: begin
                    if (alu_ack) begin
                        r_rsp_result  <= alu_result;
                        r_rsp_carry   <= alu_carry;
                        r_rsp_tag     <= r_issue_tag;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_tmr_last) begin
                        r_rsp_result  <= DATA_W'(0);
                        r_rsp_carry   <= 1'b0;
                        r_rsp_tag     <= r_issue_tag;
                        r_rsp_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: begin
                    r_timer <= r_timer;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: reset, single op, timeout, backpressure,
// simultaneous push/pop and mid-operation reset.
module tb_alu_cmd_issuer;

    logic       clk;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_opcode;
    logic [3:0] cmd_op1;
    logic [3:0] cmd_op2;
    logic [1:0] cmd_tag;
    logic       alu_req;
    logic [2:0] alu_opcode;
    logic [3:0] alu_op1;
    logic [3:0] alu_op2;
    logic       alu_ack;
    logic [3:0] alu_result_drv;
    logic       alu_carry;
    logic       use_model;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic [1:0] rsp_tag;
    logic       rsp_timeout;
    logic [2:0] fifo_count;
    logic       busy;
    wire  [3:0] alu_result = use_model ? (alu_op1 ^ 4'h5) : alu_result_drv;

    int total = 0;
    int bad   = 0;

    alu_cmd_issuer dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_tag(cmd_tag),
        .alu_req(alu_req), .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_ack(alu_ack), .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
        .fifo_count(fifo_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] tag);
        int n;
        cmd_valid = 1'b1; cmd_opcode = opc; cmd_op1 = a; cmd_op2 = b; cmd_tag = tag;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin tick; n++; end
        total++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL push_ready: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n); bad++;
        end
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req;
        int n;
        n = 0;
        while (alu_req !== 1'b1 && n < 10) begin tick; n++; end
        total++;
        if (alu_req !== 1'b1) begin $display("FAIL wait_req: alu_req=%b, required 1", alu_req); bad++; end
    endtask

    task automatic test_reset;
        rstn = 1'b0; cmd_valid = 1'b1; cmd_opcode = 3'd7; cmd_op1 = 4'hF; cmd_op2 = 4'hF;
        cmd_tag = 2'd3; alu_ack = 1'b0; alu_result_drv = 4'h0; alu_carry = 1'b0;
        use_model = 1'b0; rsp_ready = 1'b0;
        tick; tick;
        total++; if (cmd_ready !== 1'b0) begin $display("FAIL rst_cmd_ready: got %b, required 0", cmd_ready); bad++; end
        total++; if (fifo_count !== 3'd0) begin $display("FAIL rst_count: got %0d, required 0", fifo_count); bad++; end
        total++; if ({alu_req, alu_opcode, alu_op1, alu_op2} !== 12'h000) begin
            $display("FAIL rst_alu: got %h, required 000", {alu_req, alu_opcode, alu_op1, alu_op2}); bad++; end
        total++; if ({rsp_valid, rsp_result, rsp_carry, rsp_tag, rsp_timeout, busy} !== 10'h000) begin
            $display("FAIL rst_rsp: got %h, required 000", {rsp_valid, rsp_result, rsp_carry, rsp_tag, rsp_timeout, busy}); bad++; end
        cmd_valid = 1'b0;
        rstn = 1'b1;
        tick;
        total++; if (cmd_ready !== 1'b1) begin $display("FAIL rst_release_ready: got %b, required 1", cmd_ready); bad++; end
        total++; if (fifo_count !== 3'd0) begin $display("FAIL rst_no_push: got %0d, required 0", fifo_count); bad++; end
    endtask

    task automatic test_single;
        cmd_valid = 1'b1; cmd_opcode = 3'b011; cmd_op1 = 4'b0001; cmd_op2 = 4'b1000; cmd_tag = 2'd2;
        tick;
        cmd_valid = 1'b0;
        total++; if (fifo_count !== 3'd1 || alu_req !== 1'b0) begin
            $display("FAIL single_c1: count=%0d req=%b, required 1 0", fifo_count, alu_req); bad++; end
        tick;
        total++; if ({alu_req, alu_opcode, alu_op1, alu_op2} !== {1'b1, 3'b011, 4'b0001, 4'b1000}) begin
            $display("FAIL single_issue: got %h, required %h", {alu_req, alu_opcode, alu_op1, alu_op2},
                     {1'b1, 3'b011, 4'b0001, 4'b1000}); bad++; end
        total++; if (fifo_count !== 3'd0 || busy !== 1'b1) begin
            $display("FAIL single_pop: count=%0d busy=%b, required 0 1", fifo_count, busy); bad++; end
        tick;
        tick;
        alu_ack = 1'b1; alu_result_drv = 4'b1001; alu_carry = 1'b0;
        tick;
        alu_ack = 1'b0;
        total++; if ({rsp_valid, rsp_result, rsp_carry, rsp_tag, rsp_timeout, alu_req} !== {1'b1, 4'd9, 1'b0, 2'd2, 1'b0, 1'b0}) begin
            $display("FAIL single_rsp: got %h, required %h", {rsp_valid, rsp_result, rsp_carry, rsp_tag, rsp_timeout, alu_req},
                     {1'b1, 4'd9, 1'b0, 2'd2, 1'b0, 1'b0}); bad++; end
        tick;
        total++; if (rsp_valid !== 1'b1 || rsp_result !== 4'd9 || alu_op1 !== 4'b0001) begin
            $display("FAIL single_hold: valid=%b result=%0d op1=%0d, required 1 9 1", rsp_valid, rsp_result, alu_op1); bad++; end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL single_done: valid=%b busy=%b, required 0 0", rsp_valid, busy); bad++; end
    endtask

    task automatic test_timeout;
        int n;
        alu_result_drv = 4'hF; alu_carry = 1'b1;
        push(3'd1, 4'd3, 4'd4, 2'd1);
        wait_req;
        n = 0;
        while (alu_req === 1'b1 && n < 20) begin n++; tick; end
        total++; if (n !== 8) begin $display("FAIL to_req_cycles: got %0d, required 8", n); bad++; end
        total++; if ({rsp_valid, rsp_timeout, rsp_result, rsp_carry, rsp_tag} !== {1'b1, 1'b1, 4'd0, 1'b0, 2'd1}) begin
            $display("FAIL to_rsp: got %h, required %h", {rsp_valid, rsp_timeout, rsp_result, rsp_carry, rsp_tag},
                     {1'b1, 1'b1, 4'd0, 1'b0, 2'd1}); bad++; end
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
        push(3'd2, 4'd5, 4'd6, 2'd3);
        wait_req;
        repeat (7) tick;
        total++; if (alu_req !== 1'b1) begin $display("FAIL to_last_req: got %b, required 1", alu_req); bad++; end
        alu_ack = 1'b1; alu_result_drv = 4'd5; alu_carry = 1'b1;
        tick;
        alu_ack = 1'b0;
        total++; if ({rsp_valid, rsp_timeout, rsp_result, rsp_carry, rsp_tag} !== {1'b1, 1'b0, 4'd5, 1'b1, 2'd3}) begin
            $display("FAIL to_ack_wins: got %h, required %h", {rsp_valid, rsp_timeout, rsp_result, rsp_carry, rsp_tag},
                     {1'b1, 1'b0, 4'd5, 1'b1, 2'd3}); bad++; end
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [3:0] op1_t [5];
        logic [1:0] tag_t [5];
        int n;
        op1_t[0] = 4'd1; op1_t[1] = 4'd2; op1_t[2] = 4'd3; op1_t[3] = 4'd4; op1_t[4] = 4'd6;
        tag_t[0] = 2'd0; tag_t[1] = 2'd1; tag_t[2] = 2'd2; tag_t[3] = 2'd3; tag_t[4] = 2'd0;
        use_model = 1'b1; alu_ack = 1'b1; alu_carry = 1'b0;
        for (int k = 0; k < 5; k++) push(3'd4, op1_t[k], 4'd0, tag_t[k]);
        tick;
        total++; if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
            $display("FAIL bp_full: count=%0d ready=%b, required 4 0", fifo_count, cmd_ready); bad++; end
        total++; if (rsp_valid !== 1'b1 || rsp_tag !== 2'd0) begin
            $display("FAIL bp_first_held: valid=%b tag=%0d, required 1 0", rsp_valid, rsp_tag); bad++; end
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 20) begin tick; n++; end
            total++; if (rsp_valid !== 1'b1 || rsp_tag !== tag_t[k] || rsp_result !== (op1_t[k] ^ 4'h5)) begin
                $display("FAIL bp_order%0d: valid=%b tag=%0d result=%0d, required 1 %0d %0d", k, rsp_valid, rsp_tag,
                         rsp_result, tag_t[k], op1_t[k] ^ 4'h5); bad++; end
            tick;
        end
        rsp_ready = 1'b0; alu_ack = 1'b0; use_model = 1'b0;
        total++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin
            $display("FAIL bp_drained: count=%0d busy=%b, required 0 0", fifo_count, busy); bad++; end
    endtask

    task automatic test_back_to_back_pop;
        cmd_valid = 1'b1; cmd_opcode = 3'd5; cmd_op1 = 4'hA; cmd_op2 = 4'h1; cmd_tag = 2'd1;
        tick;
        total++; if (fifo_count !== 3'd1 || alu_req !== 1'b0) begin
            $display("FAIL pp_pre: count=%0d req=%b, required 1 0", fifo_count, alu_req); bad++; end
        cmd_op1 = 4'hB; cmd_tag = 2'd2;
        tick;
        total++; if (fifo_count !== 3'd1 || alu_req !== 1'b1 || alu_op1 !== 4'hA) begin
            $display("FAIL pp_same_cycle: count=%0d req=%b op1=%h, required 1 1 a", fifo_count, alu_req, alu_op1); bad++; end
        cmd_op1 = 4'hC; cmd_tag = 2'd3;
        tick;
        cmd_valid = 1'b0;
        total++; if (fifo_count !== 3'd2 || alu_req !== 1'b1) begin
            $display("FAIL pp_two_queued: count=%0d req=%b, required 2 1", fifo_count, alu_req); bad++; end
    endtask

    task automatic test_mid_reset;
        logic seen;
        rstn = 1'b0;
        #1;
        total++; if (alu_req !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
            $display("FAIL mr_async: req=%b count=%0d busy=%b, required 0 0 0", alu_req, fifo_count, busy); bad++; end
        tick;
        rstn = 1'b1;
        rsp_ready = 1'b1;
        alu_ack = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (rsp_valid === 1'b1 || alu_req === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0 || fifo_count !== 3'd0) begin
            $display("FAIL mr_no_rsp: activity=%b count=%0d, required 0 0", seen, fifo_count); bad++; end
        alu_ack = 1'b0; rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_timeout;
        test_backpressure;
        test_back_to_back_pop;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Host-side command issuer that sits in front of the 4-bit ALU.
- Buffers tagged operation commands from a host in a small FIFO and issues them one at a time on the ALU request/acknowledge interface, driving OPCODE, OP1 and OP2.
- Captures the ALU result, or flags a timeout, and returns a tagged response to the host over a valid/ready channel.
- It is the driving end of the ALU operand interface.

Parameters:
- DATA_W, 4: operand and result width.
- OPC_W, 3: opcode width.
- TAG_W, 2: command tag width.
- DEPTH, 4: command FIFO depth. Power of two, at least 2.
- TIMEOUT, 8: maximum number of cycles alu_req stays high awaiting alu_ack. Must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_opcode  in  OPC_W  operation code.
- cmd_op1  in  DATA_W  operand 1.
- cmd_op2  in  DATA_W  operand 2.
- cmd_tag  in  TAG_W  command tag, returned with the response.
- alu_req  out  1  operation request to the ALU.
- alu_opcode  out  OPC_W  opcode driven to the ALU.
- alu_op1  out  DATA_W  operand 1 driven to the ALU.
- alu_op2  out  DATA_W  operand 2 driven to the ALU.
- alu_ack  in  1  ALU result valid. Meaningful only while alu_req=1.
- alu_result  in  DATA_W  ALU result.
- alu_carry  in  1  ALU carry/flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_result  out  DATA_W  captured result.
- rsp_carry  out  1  captured carry.
- rsp_tag  out  TAG_W  tag of the completed command.
- rsp_timeout  out  1  command ended by timeout.
- fifo_count  out  $clog2(DEPTH)+1  number of queued commands.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: one clock; rstn is asynchronous, active-low. While rstn=0:
  - FSM is in IDLE and the FIFO is emptied (fifo_count=0).
  - alu_req=0, alu_opcode=0, alu_op1=0, alu_op2=0.
  - rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_tag=0, rsp_timeout=0.
  - busy=0 and cmd_ready=0. cmd_ready rises in the first cycle after release.
- Reset asserted mid-operation aborts the in-flight command, drops all queued commands and produces no response.
- FIFO:
  - cmd_ready = !full.
  - Push on the rising edge when cmd_valid & cmd_ready.
  - Pop only on the IDLE->REQ transition.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
  - Commands are issued strictly in FIFO order.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head into the issue registers (alu_opcode/op1/op2 and an internal tag), clear the timer, and go to REQ.
  - Timing: handshake in cycle t on an empty, idle block means the FIFO is non-empty from t+1 and alu_req=1 from t+2.
- REQ:
  - alu_req=1. alu_opcode/op1/op2 are held stable for the whole state.
  - alu_ack=1: capture alu_result, alu_carry and the tag; set rsp_timeout=0; go to RESP.
  - Otherwise, if timer==TIMEOUT-1: rsp_result=0, rsp_carry=0, rsp_timeout=1, capture the tag, go to RESP.
  - Otherwise the timer increments.
  - alu_req is therefore high for at most TIMEOUT cycles.
  - alu_ack in the last cycle wins over the timeout.
- RESP:
  - rsp_valid=1 and the response fields are held stable until rsp_ready=1.
  - On the handshake edge, go to IDLE. rsp_valid=0 the next cycle.
  - One IDLE bubble always separates consecutive commands.
  - alu_req=0 in RESP; alu_ack outside REQ is ignored.
- Operand outputs keep their last issued values while IDLE or RESP.
- busy=1 in REQ and RESP.
- The FIFO keeps accepting commands in all states while not full.

Test Plan:
- Reset behaviour: rstn=0 with cmd_valid=1 -> all outputs 0, fifo_count=0, cmd_ready=0. After release, cmd_ready=1 next cycle.
- Single op: push opcode=3'b011, op1=4'b0001, op2=4'b1000, tag=2 in cycle 0 -> alu_req=1 from cycle 2 with those operands. alu_ack with result=4'b1001, carry=0 in cycle 4 -> rsp_valid=1 in cycle 5 with rsp_result=9, rsp_tag=2, rsp_timeout=0.
- Timeout: TIMEOUT=8, no alu_ack -> alu_req high for exactly 8 cycles, then rsp_valid=1 with rsp_timeout=1, rsp_result=0. Repeat with alu_ack in the 8th cycle -> rsp_timeout=0 and the result is captured.
- Backpressure / full FIFO: hold rsp_ready=0 and push 5 commands (tags 0,1,2,3,0) -> first command in RESP, 4 queued, fifo_count=4, cmd_ready=0. Release rsp_ready -> responses return in tag order 0,1,2,3,0.
- Simultaneous push/pop: push in the same cycle as the IDLE->REQ pop with fifo_count=1 -> fifo_count stays 1.
- Mid-operation reset: assert rstn=0 while alu_req=1 with 2 queued commands -> alu_req=0 immediately (asynchronous). After release, fifo_count=0 and no rsp_valid ever appears.
